chebyshev_sequencer: RTL
========================

# chebyshev_sequencer

Control stage directly upstream of the Chebyshev evaluation datapath. It accepts one input sample per valid/ready handshake and holds it on the datapath operand. It then issues the polynomial coefficients highest-order first, with one Horner step per datapath pipeline round-trip. After the last step it captures the datapath result and presents it downstream with valid/ready backpressure. Coefficients live in a local register file written through a configuration port.

## Interface
- WL, 16, sample and result word length (bits)
- CL, 16, coefficient word length (bits)
- DEGREE, 7, polynomial degree N; N+1 coefficients c[0..N], N ≥ 1
- PIPE_LAT, 3, cycles from driving dp_coeff/dp_first to dp_result being valid for that step, ≥ 1
- clock  input  1  rising-edge clock
- resetn  input  1  asynchronous, active-low reset
- in_data  input  WL  signed sample x
- in_valid  input  1  sample offered
- in_ready  output  1  sequencer idle, sample accepted on in_valid & in_ready
- out_data  output  WL  signed evaluation result
- out_valid  output  1  result held and valid
- out_ready  input  1  downstream accepts result
- coef_we  input  1  coefficient write strobe
- coef_addr  input  clog2(DEGREE+1)  coefficient index k
- coef_wdata  input  CL  signed coefficient c[k]
- coef_err  output  1  one-cycle pulse: write rejected (busy, or addr > DEGREE)
- dp_data  output  WL  operand x to datapath, stable for the whole evaluation
- dp_coeff  output  CL  coefficient for the current step
- dp_first  output  1  first step; datapath uses zero feedback
- dp_result  input  WL  datapath result (trimmed, rounded)

## Operation
- FSM states: IDLE, STEP, WAIT, HOLD.
- IDLE: in_ready=1. On handshake: latch in_data into dp_data, set k=DEGREE, go to STEP.
- STEP (1 cycle): drive dp_coeff=c[k]; dp_first=1 iff k=DEGREE. Load wait counter with PIPE_LAT-1. If PIPE_LAT=1, the next state is STEP or the capture; otherwise go to WAIT.
- WAIT: decrement the counter. At 0, if k=0, capture dp_result into out_data, set out_valid and go to HOLD. Otherwise decrement k and go to STEP.
- HOLD: out_valid=1, out_data stable. On out_ready, clear out_valid and go to IDLE. in_ready rises the following cycle.
- dp_coeff and dp_first are 0 outside STEP. dp_data holds its last sample outside an evaluation.
- Coefficient writes are accepted only in IDLE with coef_addr ≤ DEGREE. Any other write leaves the register file unchanged and pulses coef_err. A write and an input handshake in the same IDLE cycle are both accepted; the evaluation uses the new coefficient.
- No arithmetic in this block: widths pass through unchanged, with no rounding or saturation.

## Timing
- Reset values (asynchronous): state=IDLE; in_ready=1 after reset release. out_data, out_valid, dp_data, dp_coeff, dp_first, coef_err and all c[k] are 0.
- Reset mid-evaluation aborts the evaluation immediately. No out_valid is produced for the aborted sample.
- Latency: handshake in cycle 0 gives out_valid at the start of cycle 1+(DEGREE+1)·PIPE_LAT.
- Throughput: one sample per 2+(DEGREE+1)·PIPE_LAT cycles with out_ready held high.
- out_valid, once asserted, stays high with constant out_data until out_ready is sampled high.
- in_ready is low from the handshake cycle+1 until the cycle after the output handshake.

## Structure
- Shared package chebyshev_pkg holds the state enum, default WL/CL/DEGREE, and the coefficient address width function. The datapath stage imports the same package.
- One sub-module, chebyshev_coef_regfile: DEGREE+1 × CL registers, async-reset to 0. It has a write port with range/busy check and one combinational read port indexed by k.
- Counter and FSM stay in the top module.

## Test plan
- Bench datapath model is an integer Horner step (y=y·x+c, y=0 on dp_first) with PIPE_LAT=2 and DEGREE=2.
- c2=1, c1=2, c0=3, x=2 → out_data=11, out_valid at cycle 7 after handshake, dp_first high only in cycle 1.
- out_ready held low for 5 cycles after out_valid → out_data stays 11, in_ready stays 0. Raising out_ready → in_ready=1 the next cycle.
- coef_we with addr=3, and coef_we during STEP → coef_err pulses each time, register file unchanged, result still 11.
- resetn pulsed low at cycle 3 of an evaluation → all outputs 0, no out_valid. A new sample x=1 after reset with zeroed coefficients → out_data=0.
- Back-to-back samples x=2, x=−1 with out_ready=1 → results 11 then 2, handshakes 8 cycles apart.
- Same-cycle coef write c0=5 and sample handshake x=2 → out_data=13.

Source files
------------

// File: rtl/chebyshev_pkg.sv
// Shared types and defaults for the Chebyshev evaluation path (sequencer and datapath).
package chebyshev_pkg;

    localparam int WL_DEF       = 16;
    localparam int CL_DEF       = 16;
    localparam int DEGREE_DEF   = 7;
    localparam int PIPE_LAT_DEF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } seq_state_e;

    // Address width for DEGREE+1 coefficients; never narrower than one bit.
    function automatic int coef_aw(input int degree);
        return (degree < 1) ? 1 : $clog2(degree + 1);
    endfunction

endpackage

// File: rtl/chebyshev_sequencer_if.sv
// Sample/result handshakes, coefficient config port and datapath operand bus.
interface chebyshev_sequencer_if #(
    parameter int WL     = chebyshev_pkg::WL_DEF,
    parameter int CL     = chebyshev_pkg::CL_DEF,
    parameter int DEGREE = chebyshev_pkg::DEGREE_DEF
);
    import chebyshev_pkg::*;

    localparam int AW = coef_aw(DEGREE);

    logic [WL-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [WL-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [CL-1:0] coef_wdata;
    logic          coef_err;
    logic [WL-1:0] dp_data;
    logic [CL-1:0] dp_coeff;
    logic          dp_first;
    logic [WL-1:0] dp_result;

    modport slave (
        input  in_data, in_valid, out_ready, coef_we, coef_addr, coef_wdata, dp_result,
        output in_ready, out_data, out_valid, coef_err, dp_data, dp_coeff, dp_first
    );

    modport master (
        output in_data, in_valid, out_ready, coef_we, coef_addr, coef_wdata, dp_result,
        input  in_ready, out_data, out_valid, coef_err, dp_data, dp_coeff, dp_first
    );

endinterface

// File: rtl/chebyshev_coef_regfile.sv
// Coefficient store c[0..DEGREE]: guarded write port, combinational read by step index.
module chebyshev_coef_regfile
    import chebyshev_pkg::*;
#(
    parameter int CL     = CL_DEF,
    parameter int DEGREE = DEGREE_DEF,
    parameter int AW     = coef_aw(DEGREE)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          busy,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [CL-1:0] wdata,
    output logic          err,
    input  logic [AW-1:0] rd_addr,
    output logic [CL-1:0] rd_data
);

    localparam int DEPTH = DEGREE + 1;

    logic [CL-1:0] regs [0:DEGREE];
    logic          in_range;
    logic          wr_ok;

    // When the depth fills the address space every index is legal.
    if ((2 ** AW) > DEPTH) begin : g_range
        assign in_range = (addr <= AW'(DEGREE));
    end else begin : g_full
        assign in_range = 1'b1;
    end

    assign wr_ok   = we && !busy && in_range;
    assign rd_data = regs[rd_addr];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i <= DEGREE; i++) begin
                regs[i] <= '0;
            end
            err <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs[addr] <= wdata;
            end
            err <= we && !wr_ok;
        end
    end

endmodule

// File: rtl/chebyshev_sequencer.sv
// Horner-step sequencer in front of the Chebyshev datapath: one coefficient per
// pipeline round-trip, highest order first, result held under backpressure.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for a sample
//   STEP  | drive c[k] (dp_first on k=DEGREE), load round-trip counter
//   WAIT  | datapath round-trip in flight; capture result after k=0
//   HOLD  | out_valid high until out_ready
module chebyshev_sequencer
    import chebyshev_pkg::*;
#(
    parameter int WL       = WL_DEF,
    parameter int CL       = CL_DEF,
    parameter int DEGREE   = DEGREE_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic                 clock,
    input  logic                 resetn,
    chebyshev_sequencer_if.slave bus
);

    localparam int AW = coef_aw(DEGREE);
    localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [AW-1:0] K_TOP    = AW'(DEGREE);
    localparam logic [CW-1:0] CNT_LOAD = CW'(PIPE_LAT - 1);

    seq_state_e    state, state_n;
    logic [AW-1:0] k, k_n;
    logic [CW-1:0] cnt, cnt_n, cnt_dec;
    logic [WL-1:0] dp_data_q, out_data_q;
    logic          out_valid_q, out_valid_n;
    logic          take_sample, capture, step_end;
    logic [CL-1:0] coef_rd, dp_coeff_c;
    logic          dp_first_c;

    chebyshev_coef_regfile #(
        .CL     (CL),
        .DEGREE (DEGREE),
        .AW     (AW)
    ) u_regfile (
        .clock   (clock),
        .resetn  (resetn),
        .busy    (state != IDLE),
        .we      (bus.coef_we),
        .addr    (bus.coef_addr),
        .wdata   (bus.coef_wdata),
        .err     (bus.coef_err),
        .rd_addr (k),
        .rd_data (coef_rd)
    );

    assign cnt_dec = cnt - CW'(1);

    always_comb begin
        state_n     = state;
        k_n         = k;
        cnt_n       = cnt;
        take_sample = 1'b0;
        capture     = 1'b0;
        step_end    = 1'b0;
        out_valid_n = out_valid_q;
        dp_coeff_c  = '0;
        dp_first_c  = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    take_sample = 1'b1;
                    k_n         = K_TOP;
                    state_n     = STEP;
                end
            end
            STEP: begin
                dp_coeff_c = coef_rd;
                dp_first_c = (k == K_TOP);
                cnt_n      = CNT_LOAD;
                state_n    = WAIT;
                step_end   = (PIPE_LAT == 1);
            end
            WAIT: begin
                cnt_n    = cnt_dec;
                step_end = (cnt_dec == '0);
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // End of a round-trip: either the last coefficient's result is ready, or issue the next one.
        if (step_end) begin
            if (k == '0) begin
                capture     = 1'b1;
                out_valid_n = 1'b1;
                state_n     = HOLD;
            end else begin
                k_n     = k - AW'(1);
                state_n = STEP;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            k           <= '0;
            cnt         <= '0;
            dp_data_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_n;
            k           <= k_n;
            cnt         <= cnt_n;
            out_valid_q <= out_valid_n;
            if (take_sample) begin
                dp_data_q <= bus.in_data;
            end
            if (capture) begin
                out_data_q <= bus.dp_result;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.dp_data   = dp_data_q;
    assign bus.dp_coeff  = dp_coeff_c;
    assign bus.dp_first  = dp_first_c;

endmodule
